// File: rtl/pa_key_streamer.sv
// Captures privacy-amplification key words into a FIFO and streams them out over valid/ready,
// marking the final word of each session and keeping sticky finish/fail/length status.
module pa_key_streamer #(
  parameter int unsigned KEY_W      = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clock_100M,
  input  logic               reset,
  input  logic               start,
  input  logic               clear_status,
  input  logic [CNT_W-1:0]   expected_words,
  input  logic               key_en,
  input  logic [KEY_W/8-1:0] key_we,
  input  logic [KEY_W-1:0]   key_din,
  input  logic               pa_finish,
  input  logic               pa_fail,
  output logic [KEY_W-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               finish_flag,
  output logic               fail_flag,
  output logic               overflow_flag,
  output logic               length_err,
  output logic [CNT_W-1:0]   words_in,
  output logic [CNT_W-1:0]   words_out,
  output logic [7:0]         status_vec
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StDrain   = 3'd2,
    StDone    = 3'd3,
    StFail    = 3'd4
  } state_e;

  state_e           state_q;
  logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CNT_W-1:0] expected_q;

  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             go_fail;
  logic             flush;
  logic [CNT_W-1:0] words_in_nxt;

  always_comb begin
    fifo_full = (count_q == FullCnt);
    push_req  = (state_q == StCollect) && key_en && (|key_we);
    // Full is judged on the pre-edge count, so a simultaneous pop cannot rescue a push.
    overflow  = push_req && fifo_full;
    push      = push_req && !fifo_full;

    m_valid = 1'b0;
    m_last  = 1'b0;
    case (state_q)
      // One word is held back during collection so the final word can carry m_last.
      StCollect: m_valid = (count_q >= CW'(2));
      StDrain: begin
        m_valid = (count_q != '0);
        m_last  = (count_q == CW'(1));
      end
      default: begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
    endcase

    pop          = m_valid && m_ready;
    words_in_nxt = (push && (words_in != CntMax)) ? words_in + 1'b1 : words_in;
    go_fail      = (state_q == StCollect) && !clear_status && (pa_fail || overflow);
    flush        = clear_status || go_fail || (state_q == StFail);
  end

  assign m_data     = mem_q[rd_ptr_q];
  assign status_vec = {fifo_full, overflow_flag, length_err, fail_flag, finish_flag, state_q};

  always_ff @(posedge clock_100M or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= key_din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock_100M or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      expected_q    <= '0;
      words_in      <= '0;
      words_out     <= '0;
      finish_flag   <= 1'b0;
      fail_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      length_err    <= 1'b0;
    end else if (clear_status) begin
      state_q       <= StIdle;
      finish_flag   <= 1'b0;
      fail_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      length_err    <= 1'b0;
    end else begin
      if (pop && (words_out != CntMax)) begin
        words_out <= words_out + 1'b1;
      end
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StCollect;
            expected_q <= expected_words;
            words_in   <= '0;
            words_out  <= '0;
            length_err <= 1'b0;
          end
        end
        StCollect: begin
          words_in <= words_in_nxt;
          if (pa_fail || overflow) begin
            state_q   <= StFail;
            fail_flag <= 1'b1;
            if (overflow) begin
              overflow_flag <= 1'b1;
            end
          end else if (pa_finish) begin
            length_err <= (words_in_nxt != expected_q);
            // An empty session has nothing to drain and completes immediately.
            if ((count_q == '0) && !push) begin
              state_q     <= StDone;
              finish_flag <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
            state_q     <= StDone;
            finish_flag <= 1'b1;
          end
        end
        StFail: begin
          state_q <= StFail;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pa_key_streamer.sv
// Directed bench for pa_key_streamer: a per-cycle vector table for full sessions plus
// hand-written sequences for overflow, fail/finish collision, empty session and async reset.
module tb_pa_key_streamer;

  logic        clock_100M;
  logic        reset;
  logic        start;
  logic        clear_status;
  logic [15:0] expected_words;
  logic        key_en;
  logic [7:0]  key_we;
  logic [63:0] key_din;
  logic        pa_finish;
  logic        pa_fail;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        finish_flag;
  logic        fail_flag;
  logic        overflow_flag;
  logic        length_err;
  logic [15:0] words_in;
  logic [15:0] words_out;
  logic [7:0]  status_vec;

  pa_key_streamer #(
    .KEY_W      (64),
    .FIFO_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clock_100M     (clock_100M),
    .reset          (reset),
    .start          (start),
    .clear_status   (clear_status),
    .expected_words (expected_words),
    .key_en         (key_en),
    .key_we         (key_we),
    .key_din        (key_din),
    .pa_finish      (pa_finish),
    .pa_fail        (pa_fail),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .finish_flag    (finish_flag),
    .fail_flag      (fail_flag),
    .overflow_flag  (overflow_flag),
    .length_err     (length_err),
    .words_in       (words_in),
    .words_out      (words_out),
    .status_vec     (status_vec)
  );

  initial begin
    clock_100M = 1'b0;
    forever #5 clock_100M = ~clock_100M;
  end

  // ctl = {start, clear_status, key_en, pa_finish, pa_fail, m_ready}
  // ex  = {m_valid, m_last, check_counters}
  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] ew;
    logic [7:0]  we;
    logic [63:0] din;
    logic [2:0]  ex;
    logic [63:0] ed;
    logic [7:0]  es;
    logic [15:0] ewi;
    logic [15:0] ewo;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  function automatic logic [63:0] dw(input logic [7:0] set, input logic [7:0] k);
    return {16'hC0DE, set, k, 8'h55, k, set, 8'hAA};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] ctl, input logic [15:0] ew, input logic [7:0] we,
                     input logic [63:0] din, input logic [2:0] ex, input logic [63:0] ed,
                     input logic [7:0] es, input logic [15:0] ewi, input logic [15:0] ewo);
    vec_t v;
    v.ctl = ctl; v.ew = ew; v.we = we; v.din = din;
    v.ex = ex; v.ed = ed; v.es = es; v.ewi = ewi; v.ewo = ewo;
    vq.push_back(v);
  endtask

  task automatic step(input logic [5:0] ctl, input logic [15:0] ew, input logic [7:0] we,
                      input logic [63:0] din);
    start          = ctl[5];
    clear_status   = ctl[4];
    key_en         = ctl[3];
    pa_finish      = ctl[2];
    pa_fail        = ctl[1];
    m_ready        = ctl[0];
    expected_words = ew;
    key_we         = we;
    key_din        = din;
    @(posedge clock_100M);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0; clear_status = 1'b0; expected_words = '0; key_en = 1'b0;
    key_we = '0; key_din = '0; pa_finish = 1'b0; pa_fail = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clock_100M);
    #1;
    chk("reset status", 64'(status_vec), 64'h00);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_last", 64'(m_last), 64'd0);
    chk("reset m_data", m_data, 64'h0);
    chk("reset words_in", 64'(words_in), 64'd0);
    chk("reset words_out", 64'(words_out), 64'd0);
    reset = 1'b0;

    // Session A: expect 5, ready high, partial byte enables still store whole words.
    add(6'b100001, 16'd5, 8'h00, 64'h0,         3'b001, 64'h0,         8'h01, 16'd0, 16'd0);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd1,8'd0), 3'b001, 64'h0,         8'h01, 16'd1, 16'd0);
    add(6'b001001, 16'd0, 8'h01, dw(8'd1,8'd1), 3'b101, dw(8'd1,8'd0), 8'h01, 16'd2, 16'd0);
    add(6'b001001, 16'd0, 8'h80, dw(8'd1,8'd2), 3'b101, dw(8'd1,8'd1), 8'h01, 16'd3, 16'd1);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd1,8'd3), 3'b101, dw(8'd1,8'd2), 8'h01, 16'd4, 16'd2);
    add(6'b001101, 16'd0, 8'hFF, dw(8'd1,8'd4), 3'b101, dw(8'd1,8'd3), 8'h02, 16'd5, 16'd3);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b111, dw(8'd1,8'd4), 8'h02, 16'd5, 16'd4);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b001, 64'h0,         8'h0B, 16'd5, 16'd5);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd1,8'd9), 3'b001, 64'h0,         8'h0B, 16'd5, 16'd5);
    add(6'b010001, 16'd0, 8'h00, 64'h0,         3'b000, 64'h0,         8'h00, 16'd0, 16'd0);
    // Session B: expect 5, ready low while collecting, key_en low blocks a push.
    add(6'b100000, 16'd5, 8'h00, 64'h0,         3'b001, 64'h0,         8'h01, 16'd0, 16'd0);
    add(6'b001000, 16'd0, 8'hFF, dw(8'd2,8'd0), 3'b001, 64'h0,         8'h01, 16'd1, 16'd0);
    add(6'b001000, 16'd0, 8'hFF, dw(8'd2,8'd1), 3'b101, dw(8'd2,8'd0), 8'h01, 16'd2, 16'd0);
    add(6'b000000, 16'd0, 8'hFF, dw(8'd2,8'd9), 3'b101, dw(8'd2,8'd0), 8'h01, 16'd2, 16'd0);
    add(6'b001000, 16'd0, 8'hFF, dw(8'd2,8'd2), 3'b101, dw(8'd2,8'd0), 8'h01, 16'd3, 16'd0);
    add(6'b001000, 16'd0, 8'hFF, dw(8'd2,8'd3), 3'b101, dw(8'd2,8'd0), 8'h01, 16'd4, 16'd0);
    add(6'b001100, 16'd0, 8'hFF, dw(8'd2,8'd4), 3'b101, dw(8'd2,8'd0), 8'h02, 16'd5, 16'd0);
    add(6'b000000, 16'd0, 8'h00, 64'h0,         3'b101, dw(8'd2,8'd0), 8'h02, 16'd5, 16'd0);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b101, dw(8'd2,8'd1), 8'h02, 16'd5, 16'd1);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b101, dw(8'd2,8'd2), 8'h02, 16'd5, 16'd2);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b101, dw(8'd2,8'd3), 8'h02, 16'd5, 16'd3);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b111, dw(8'd2,8'd4), 8'h02, 16'd5, 16'd4);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b001, 64'h0,         8'h0B, 16'd5, 16'd5);
    // Session C from DONE: finish_flag kept, expect 8 but only 6 arrive.
    add(6'b100001, 16'd8, 8'h00, 64'h0,         3'b001, 64'h0,         8'h09, 16'd0, 16'd0);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd3,8'd0), 3'b001, 64'h0,         8'h09, 16'd1, 16'd0);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd3,8'd1), 3'b101, dw(8'd3,8'd0), 8'h09, 16'd2, 16'd0);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd3,8'd2), 3'b101, dw(8'd3,8'd1), 8'h09, 16'd3, 16'd1);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd3,8'd3), 3'b101, dw(8'd3,8'd2), 8'h09, 16'd4, 16'd2);
    add(6'b001001, 16'd0, 8'hFF, dw(8'd3,8'd4), 3'b101, dw(8'd3,8'd3), 8'h09, 16'd5, 16'd3);
    add(6'b001101, 16'd0, 8'hFF, dw(8'd3,8'd5), 3'b101, dw(8'd3,8'd4), 8'h2A, 16'd6, 16'd4);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b111, dw(8'd3,8'd5), 8'h2A, 16'd6, 16'd5);
    add(6'b000001, 16'd0, 8'h00, 64'h0,         3'b001, 64'h0,         8'h2B, 16'd6, 16'd6);
    add(6'b010001, 16'd0, 8'h00, 64'h0,         3'b000, 64'h0,         8'h00, 16'd0, 16'd0);
    // IDLE ignores pushes and pa_finish.
    add(6'b001101, 16'd0, 8'hFF, dw(8'd3,8'd7), 3'b000, 64'h0,         8'h00, 16'd0, 16'd0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      step(v.ctl, v.ew, v.we, v.din);
      chk($sformatf("row%0d status", i), 64'(status_vec), 64'(v.es));
      chk($sformatf("row%0d m_valid", i), 64'(m_valid), 64'(v.ex[2]));
      chk($sformatf("row%0d m_last", i), 64'(m_last), 64'(v.ex[1]));
      chk($sformatf("row%0d finish", i), 64'(finish_flag), 64'(v.es[3]));
      chk($sformatf("row%0d fail", i), 64'(fail_flag), 64'(v.es[4]));
      chk($sformatf("row%0d len_err", i), 64'(length_err), 64'(v.es[5]));
      chk($sformatf("row%0d ovf", i), 64'(overflow_flag), 64'(v.es[6]));
      if (v.ex[2]) chk($sformatf("row%0d m_data", i), m_data, v.ed);
      if (v.ex[0]) begin
        chk($sformatf("row%0d words_in", i), 64'(words_in), 64'(v.ewi));
        chk($sformatf("row%0d words_out", i), 64'(words_out), 64'(v.ewo));
      end
    end

    // Overflow: 17 pushes into a 16-deep FIFO with ready low.
    step(6'b100000, 16'd16, 8'h00, 64'h0);
    for (int i = 0; i < 16; i++) step(6'b001000, 16'd0, 8'hFF, dw(8'd4, 8'(i)));
    chk("ovf full status", 64'(status_vec), 64'h81);
    chk("ovf full valid", 64'(m_valid), 64'd1);
    chk("ovf full head", m_data, dw(8'd4, 8'd0));
    chk("ovf full words_in", 64'(words_in), 64'd16);
    step(6'b001000, 16'd0, 8'hFF, dw(8'd4, 8'd16));
    chk("ovf fail status", 64'(status_vec[6:0]), 64'h54);
    chk("ovf fail valid", 64'(m_valid), 64'd0);
    chk("ovf fail words_in", 64'(words_in), 64'd16);
    step(6'b000000, 16'd0, 8'h00, 64'h0);
    chk("ovf flushed status", 64'(status_vec), 64'h54);
    step(6'b010000, 16'd0, 8'h00, 64'h0);
    chk("ovf clear status", 64'(status_vec), 64'h00);
    chk("ovf clear flags", 64'({overflow_flag, fail_flag}), 64'd0);

    // pa_finish and pa_fail together after 3 pushes: fail wins, nothing emitted.
    step(6'b100000, 16'd3, 8'h00, 64'h0);
    for (int i = 0; i < 3; i++) step(6'b001000, 16'd0, 8'hFF, dw(8'd6, 8'(i)));
    chk("ff pre valid", 64'(m_valid), 64'd1);
    step(6'b000110, 16'd0, 8'h00, 64'h0);
    chk("ff status", 64'(status_vec[6:0]), 64'h14);
    chk("ff finish", 64'(finish_flag), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(6'b000001, 16'd0, 8'h00, 64'h0);
      chk($sformatf("ff valid%0d", i), 64'(m_valid), 64'd0);
    end
    chk("ff words_out", 64'(words_out), 64'd0);
    chk("ff final status", 64'(status_vec), 64'h14);
    step(6'b010000, 16'd0, 8'h00, 64'h0);
    chk("ff clear status", 64'(status_vec), 64'h00);

    // Empty session: finish with no words goes straight to DONE.
    step(6'b100001, 16'd0, 8'h00, 64'h0);
    chk("zero collect", 64'(status_vec), 64'h01);
    step(6'b000101, 16'd0, 8'h00, 64'h0);
    chk("zero done status", 64'(status_vec), 64'h0B);
    chk("zero done valid", 64'(m_valid), 64'd0);
    step(6'b000001, 16'd0, 8'h00, 64'h0);
    chk("zero idle valid", 64'(m_valid), 64'd0);
    chk("zero words_out", 64'(words_out), 64'd0);
    step(6'b010000, 16'd0, 8'h00, 64'h0);

    // Asynchronous reset while draining.
    step(6'b100000, 16'd2, 8'h00, 64'h0);
    step(6'b001000, 16'd0, 8'hFF, dw(8'd5, 8'd0));
    step(6'b001100, 16'd0, 8'hFF, dw(8'd5, 8'd1));
    chk("rst pre status", 64'(status_vec), 64'h02);
    chk("rst pre valid", 64'(m_valid), 64'd1);
    chk("rst pre data", m_data, dw(8'd5, 8'd0));
    #3;
    reset = 1'b1;
    #1;
    chk("rst async status", 64'(status_vec), 64'h00);
    chk("rst async valid", 64'(m_valid), 64'd0);
    chk("rst async last", 64'(m_last), 64'd0);
    chk("rst async data", m_data, 64'h0);
    chk("rst async counters", 64'({words_in, words_out}), 64'd0);
    @(posedge clock_100M);
    #1;
    reset = 1'b0;
    step(6'b000001, 16'd0, 8'h00, 64'h0);
    chk("rst after status", 64'(status_vec), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
